// File: rtl/bin_gray_encoder.sv
// -----------------------------------------------------------------------------
// bin_gray_encoder
// Sequential binary-to-Gray encoder (inverse of the Gray-to-binary LED decoder).
// Loads a binary word over a valid/ready handshake and holds its registered
// Gray code until the consumer accepts it. It can also free-run as an up/down
// Gray counter, stepping once every DIV clock cycles.
//
// Optional build macro: GRAY_SELFCHK_EN
//    When defined, adds output chk_err: a sticky flag set when an internal
//    Gray-to-binary decode of gray_out disagrees with the binary register.
//    Only a reset clears it.
//
// Parameters:
//    WIDTH     data width in bits (2..16)
//    DIV       clock cycles per count step in COUNT (>= 2)
//
// Ports:
//    clk        system clock, rising edge
//    rst_n      synchronous active-low reset
//    bin_in     binary word to encode
//    in_valid   bin_in is valid
//    in_ready   encoder can accept bin_in (IDLE or COUNT)
//    cnt_en     request free-run Gray counting
//    cnt_dir    count direction: 1 = up, 0 = down
//    gray_out   registered Gray code of the binary register
//    out_valid  gray_out valid (held in CONV, 1-cycle pulse per COUNT step)
//    out_ready  consumer accepts gray_out (CONV only)
//    wrap       1-cycle pulse when the counter wraps
//    chk_err    sticky self-check error (GRAY_SELFCHK_EN only)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a load or a count request; gray_out holds
// CONV  | loaded word presented; waiting for out_ready
// COUNT | free-running; prescaler paces one step every DIV cycles
// -----------------------------------------------------------------------------
module bin_gray_encoder #(
   parameter int WIDTH = 4,
   parameter int DIV   = 27000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] bin_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             cnt_en,
   input  logic             cnt_dir,
   output logic [WIDTH-1:0] gray_out,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef GRAY_SELFCHK_EN
   output logic             chk_err,
`endif
   output logic             wrap
);

   localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      COUNT = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] bin_q;
   logic [PRE_W-1:0] prescaler;
   logic [WIDTH-1:0] bin_step;
   logic             step_wraps;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign in_ready = (state != CONV);

   // Next counter value and whether that step crosses the all-ones/zero seam.
   assign bin_step   = cnt_dir ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
   assign step_wraps = cnt_dir ? (bin_q == '1) : (bin_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         bin_q     <= '0;
         gray_out  <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         prescaler <= '0;
      end else begin
         case (state)
            IDLE: begin
               wrap      <= 1'b0;
               out_valid <= 1'b0;
               if (in_valid) begin
                  bin_q     <= bin_in;
                  gray_out  <= to_gray(bin_in);
                  out_valid <= 1'b1;
                  state     <= CONV;
               end else if (cnt_en) begin
                  prescaler <= '0;
                  state     <= COUNT;
               end
            end

            CONV: begin
               wrap <= 1'b0;
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            COUNT: begin
               // A load pre-empts any tick due in the same cycle.
               if (in_valid) begin
                  bin_q     <= bin_in;
                  gray_out  <= to_gray(bin_in);
                  out_valid <= 1'b1;
                  wrap      <= 1'b0;
                  state     <= CONV;
               end else if (!cnt_en) begin
                  prescaler <= '0;
                  out_valid <= 1'b0;
                  wrap      <= 1'b0;
                  state     <= IDLE;
               end else if (prescaler == PRE_W'(DIV - 1)) begin
                  prescaler <= '0;
                  bin_q     <= bin_step;
                  gray_out  <= to_gray(bin_step);
                  out_valid <= 1'b1;
                  wrap      <= step_wraps;
               end else begin
                  prescaler <= prescaler + PRE_W'(1);
                  out_valid <= 1'b0;
                  wrap      <= 1'b0;
               end
            end

            default: begin
               out_valid <= 1'b0;
               wrap      <= 1'b0;
               prescaler <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef GRAY_SELFCHK_EN
   logic [WIDTH-1:0] gray_dec;

   // Independent Gray-to-binary decode: each binary bit is the XOR of all
   // Gray bits at or above it.
   always_comb begin
      gray_dec = '0;
      gray_dec[WIDTH-1] = gray_out[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         gray_dec[i] = gray_dec[i+1] ^ gray_out[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chk_err <= 1'b0;
      end else if (gray_dec != bin_q) begin
         chk_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bin_gray_encoder.sv
module tb_bin_gray_encoder;

   localparam int WIDTH = 4;
   localparam int DIV   = 4;
   localparam int MODV  = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] bin_in;
   logic             in_valid;
   logic             in_ready;
   logic             cnt_en;
   logic             cnt_dir;
   logic [WIDTH-1:0] gray_out;
   logic             out_valid;
   logic             out_ready;
   logic             wrap;
`ifdef GRAY_SELFCHK_EN
   logic             chk_err;
`endif

   bin_gray_encoder #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bin_in    (bin_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cnt_en    (cnt_en),
      .cnt_dir   (cnt_dir),
      .gray_out  (gray_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef GRAY_SELFCHK_EN
      .chk_err   (chk_err),
`endif
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: mode 0 = idle, 1 = holding a loaded word, 2 = counting.
   // m_cyc counts cycles spent counting since the last step (or since entry).
   int m_mode, m_val, m_cyc, m_ov, m_wrap, m_stepped;
   logic [WIDTH-1:0] prev_gray;

   function automatic int gray_of(input int v);
      return v ^ (v / 2);
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_load();
      m_val  = int'(bin_in);
      m_ov   = 1;
      m_wrap = 0;
      m_mode = 1;
   endtask

   task automatic model_update();
      m_stepped = 0;
      if (!rst_n) begin
         m_mode = 0; m_val = 0; m_cyc = 0; m_ov = 0; m_wrap = 0;
      end else if (m_mode == 0) begin
         m_ov = 0; m_wrap = 0;
         if (in_valid) model_load();
         else if (cnt_en) begin m_mode = 2; m_cyc = 0; end
      end else if (m_mode == 1) begin
         if (out_ready) begin m_ov = 0; m_mode = 0; end
      end else begin
         if (in_valid) model_load();
         else if (!cnt_en) begin
            m_mode = 0; m_cyc = 0; m_ov = 0; m_wrap = 0;
         end else if (m_cyc + 1 == DIV) begin
            m_cyc = 0;
            m_ov  = 1;
            m_stepped = 1;
            if (cnt_dir) begin
               m_wrap = (m_val + 1 >= MODV);
               m_val  = (m_val + 1) % MODV;
            end else begin
               m_wrap = (m_val - 1 < 0);
               m_val  = (m_val + MODV - 1) % MODV;
            end
         end else begin
            m_cyc++;
            m_ov = 0; m_wrap = 0;
         end
      end
   endtask

   // One clock: predict from current inputs, clock, then check every output.
   task automatic tick();
      prev_gray = gray_out;
      model_update();
      @(posedge clk);
      #1;
      cmp("gray_out",  int'(gray_out),  gray_of(m_val));
      cmp("out_valid", int'(out_valid), m_ov);
      cmp("wrap",      int'(wrap),      m_wrap);
      cmp("in_ready",  int'(in_ready),  (m_mode != 1) ? 1 : 0);
`ifdef GRAY_SELFCHK_EN
      cmp("chk_err",   int'(chk_err),   0);
`endif
      if (m_stepped) cmp("one_bit_step", $countones(prev_gray ^ gray_out), 1);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; cnt_en = 1'b0; cnt_dir = 1'b1; out_ready = 1'b0;
      bin_in = '0;
   endtask

   // Load a word and accept it on the following cycle.
   task automatic load_accept(input logic [WIDTH-1:0] v);
      idle_inputs();
      bin_in = v; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   typedef struct {
      logic [WIDTH-1:0] bin;
      logic [WIDTH-1:0] gray;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{4'b0110, 4'b0101};
      tbl[1] = '{4'b1010, 4'b1111};
      tbl[2] = '{4'b1111, 4'b1000};
      tbl[3] = '{4'b0000, 4'b0000};
      tbl[4] = '{4'b0011, 4'b0010};
      tbl[5] = '{4'b0101, 4'b0111};
      tbl[6] = '{4'b0111, 4'b0100};
      tbl[7] = '{4'b1001, 4'b1101};

      idle_inputs();
      rst_n = 1'b0;
      m_mode = 0; m_val = 0; m_cyc = 0; m_ov = 0; m_wrap = 0;
      tick();
      tick();
      cmp("reset_gray", int'(gray_out), 0);
      cmp("reset_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;

      // Table-driven loads with immediate acceptance.
      foreach (tbl[i]) begin
         idle_inputs();
         bin_in = tbl[i].bin; in_valid = 1'b1; out_ready = 1'b1;
         tick();
         cmp("tbl_gray", int'(gray_out), int'(tbl[i].gray));
         cmp("tbl_valid", int'(out_valid), 1);
         in_valid = 1'b0;
         tick();
         cmp("tbl_done_valid", int'(out_valid), 0);
         cmp("tbl_done_ready", int'(in_ready), 1);
      end

      // Backpressure: second word must be dropped while the first is held.
      idle_inputs();
      bin_in = 4'b0011; in_valid = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         in_valid = (k == 2);
         bin_in   = 4'b1001;
         tick();
         cmp("bp_gray", int'(gray_out), 4'b0010);
         cmp("bp_valid", int'(out_valid), 1);
         cmp("bp_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      cmp("bp_release", int'(in_ready), 1);

      // Count up from 0111.
      load_accept(4'b0111);
      idle_inputs();
      cnt_en = 1'b1; cnt_dir = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         cmp("up_no_step", int'(out_valid), 0);
      end
      tick();
      cmp("up_step1", int'(gray_out), 4'b1100);
      cmp("up_step1_valid", int'(out_valid), 1);
      tick();
      cmp("up_pulse_end", int'(out_valid), 0);
      for (int k = 0; k < 3; k++) tick();
      cmp("up_step2", int'(gray_out), 4'b1101);
      cnt_en = 1'b0;
      tick();

      // Wrap upward from all-ones.
      load_accept(4'b1111);
      idle_inputs();
      cnt_en = 1'b1; cnt_dir = 1'b1;
      for (int k = 0; k < DIV + 1; k++) tick();
      cmp("wrap_up_gray", int'(gray_out), 0);
      cmp("wrap_up", int'(wrap), 1);
      tick();
      cmp("wrap_up_pulse", int'(wrap), 0);
      cnt_en = 1'b0;
      tick();

      // Wrap downward from zero.
      load_accept(4'b0000);
      idle_inputs();
      cnt_en = 1'b1; cnt_dir = 1'b0;
      for (int k = 0; k < DIV + 1; k++) tick();
      cmp("wrap_dn_gray", int'(gray_out), 4'b1000);
      cmp("wrap_dn", int'(wrap), 1);
      cnt_en = 1'b0;
      tick();

      // Load beats a tick landing on the same edge.
      load_accept(4'b0010);
      idle_inputs();
      cnt_en = 1'b1; cnt_dir = 1'b1;
      for (int k = 0; k < DIV; k++) tick();
      bin_in = 4'b0101; in_valid = 1'b1;
      tick();
      cmp("prio_gray", int'(gray_out), 4'b0111);
      cmp("prio_ready", int'(in_ready), 0);
      cmp("prio_wrap", int'(wrap), 0);
      in_valid = 1'b0; cnt_en = 1'b0; out_ready = 1'b1;
      tick();

      // Reset during counting, landing on a step pulse.
      idle_inputs();
      cnt_en = 1'b1; cnt_dir = 1'b0;
      for (int k = 0; k < DIV + 1; k++) tick();
      rst_n = 1'b0;
      tick();
      cmp("rst_gray", int'(gray_out), 0);
      cmp("rst_valid", int'(out_valid), 0);
      cmp("rst_wrap", int'(wrap), 0);
`ifdef GRAY_SELFCHK_EN
      cmp("rst_chk_err", int'(chk_err), 0);
`endif
      rst_n = 1'b1;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst_n     = ($urandom_range(0, 299) != 0);
         in_valid  = ($urandom_range(0, 11) == 0);
         bin_in    = WIDTH'($urandom_range(0, MODV - 1));
         cnt_en    = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) cnt_dir = ~cnt_dir;
         out_ready = $urandom_range(0, 1) != 0;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
